// File: rtl/cv32e40p_mult_tmr_ctrl.sv
// Purpose:  fault manager for the triplicated multiplier: per-replica leaky-bucket error
//           counters, faulty-replica masking, retry on no-majority, sticky fatal flag.
// Latency:  all status outputs are registered, 1 cycle after the compare event (retry_o 2).
// Backpressure: none; a compare is taken only when enable_i & ready_voted_i & ex_ready_i.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   enable_i           multiplier enable seen by the replicas
//   ex_ready_i         EX stage ready seen by the replicas
//   ready_voted_i      voted ready of the triplicated multiplier
//   result_tmr_i       replica results, [32*i +: 32] = replica i
//   ready_tmr_i        per-replica ready
//   multicycle_tmr_i   per-replica multicycle
//   mulh_tmr_i         per-replica mulh_active
//   clear_i            synchronous clear of all fault state
//   replica_ok_o       healthy mask (1 = replica trusted by the voters)
//   err_cnt_o          per-replica error counters, [ERR_CNT_W*i +: ERR_CNT_W] = replica i
//   corr_pulse_o       one-cycle pulse: a single-replica mismatch was outvoted
//   retry_o            one-cycle request to flush and re-issue the multiply
//   fatal_o            sticky unrecoverable-fault flag
module cv32e40p_mult_tmr_ctrl #(
  parameter int ERR_CNT_W     = 4,
  parameter int ERR_THRESHOLD = 8,
  parameter int DECAY_PERIOD  = 1024,
  parameter int MAX_RETRY     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable_i,
  input  logic                   ex_ready_i,
  input  logic                   ready_voted_i,
  input  logic [95:0]            result_tmr_i,
  input  logic [2:0]             ready_tmr_i,
  input  logic [2:0]             multicycle_tmr_i,
  input  logic [2:0]             mulh_tmr_i,
  input  logic                   clear_i,
  output logic [2:0]             replica_ok_o,
  output logic [3*ERR_CNT_W-1:0] err_cnt_o,
  output logic                   corr_pulse_o,
  output logic                   retry_o,
  output logic                   fatal_o
);

  localparam int TMR_W = $clog2(DECAY_PERIOD);
  localparam int RC_W  = $clog2(MAX_RETRY + 1);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [ERR_CNT_W-1:0] CNT_THR  = ERR_CNT_W'(ERR_THRESHOLD);
  localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(DECAY_PERIOD - 1);
  localparam logic [RC_W-1:0]      RC_MAX   = RC_W'(MAX_RETRY);

  typedef enum logic [1:0] {
    MON   = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    FATAL = 2'd3
  } state_t;

  state_t                      state_q, state_nxt;
  logic [RC_W-1:0]             rcnt_q, rcnt_nxt;
  logic [TMR_W-1:0]            timer_q, timer_nxt;
  logic [2:0][ERR_CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [2:0]                  ok_q, ok_nxt;
  logic                        corr_q, retry_q, fatal_q;

  logic [31:0] r0, r1, r2, maj_res;
  logic        maj_rdy, maj_mc, maj_mh;
  logic [2:0]  mism, inc, dec;
  logic        cmp, nomaj, tick, two_faulty;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
  endfunction

  // Majority and mismatch detection are purely combinational on the replica outputs.
  assign r0      = result_tmr_i[31:0];
  assign r1      = result_tmr_i[63:32];
  assign r2      = result_tmr_i[95:64];
  assign maj_res = (r0 & r1) | (r1 & r2) | (r0 & r2);
  assign maj_rdy = maj3(ready_tmr_i);
  assign maj_mc  = maj3(multicycle_tmr_i);
  assign maj_mh  = maj3(mulh_tmr_i);

  always_comb begin
    mism = '0;
    for (int i = 0; i < 3; i++) begin
      mism[i] = (result_tmr_i[32*i +: 32] != maj_res) |
                (ready_tmr_i[i]      != maj_rdy) |
                (multicycle_tmr_i[i] != maj_mc)  |
                (mulh_tmr_i[i]       != maj_mh);
    end
  end

  assign cmp        = enable_i & ready_voted_i & ex_ready_i;
  assign nomaj      = (r0 != r1) & (r1 != r2) & (r0 != r2);
  assign tick       = (timer_q == TMR_LAST);
  assign two_faulty = maj3(~ok_q);

  // Counter update: an increment on a replica beats a same-cycle decay tick for that
  // replica only. Faulty replicas are frozen (both directions).
  always_comb begin
    cnt_nxt = cnt_q;
    ok_nxt  = ok_q;
    inc     = '0;
    dec     = '0;
    for (int i = 0; i < 3; i++) begin
      inc[i] = cmp & mism[i] & ok_q[i] & ~nomaj;
      dec[i] = tick & ok_q[i] & ~inc[i] & (cnt_q[i] != '0);
      if (inc[i]) begin
        if (cnt_q[i] != CNT_MAX) cnt_nxt[i] = cnt_q[i] + ERR_CNT_W'(1);
      end else if (dec[i]) begin
        cnt_nxt[i] = cnt_q[i] - ERR_CNT_W'(1);
      end
      ok_nxt[i] = ok_q[i] & (cnt_nxt[i] < CNT_THR);
    end
    timer_nxt = ((|inc) | tick) ? '0 : timer_q + TMR_W'(1);
  end

  always_comb begin
    state_nxt = state_q;
    rcnt_nxt  = rcnt_q;
    unique case (state_q)
      MON: begin
        if (cmp && nomaj) begin
          state_nxt = REQ;
          rcnt_nxt  = RC_W'(1);
        end else if (two_faulty) begin
          state_nxt = FATAL;
        end
      end
      REQ: state_nxt = WAIT;
      WAIT: begin
        if (cmp) begin
          if (!nomaj) begin
            state_nxt = MON;
            rcnt_nxt  = '0;
          end else if (rcnt_q == RC_MAX) begin
            state_nxt = FATAL;
          end else begin
            state_nxt = REQ;
            rcnt_nxt  = rcnt_q + RC_W'(1);
          end
        end
      end
      FATAL: state_nxt = FATAL;
      default: state_nxt = MON;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MON;
      rcnt_q  <= '0;
    end else if (clear_i) begin
      state_q <= MON;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_nxt;
      rcnt_q  <= rcnt_nxt;
    end
  end

  // retry_o is driven from the REQ state itself, so the request lands two cycles after
  // the failing compare; fatal_o tracks the next state so it lands after one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      ok_q    <= 3'b111;
      timer_q <= '0;
      corr_q  <= 1'b0;
      retry_q <= 1'b0;
      fatal_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q   <= '0;
      ok_q    <= 3'b111;
      timer_q <= '0;
      corr_q  <= 1'b0;
      retry_q <= 1'b0;
      fatal_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_nxt;
      ok_q    <= ok_nxt;
      timer_q <= timer_nxt;
      corr_q  <= cmp & (|mism) & ~nomaj;
      retry_q <= (state_q == REQ);
      fatal_q <= (state_nxt == FATAL);
    end
  end

  assign replica_ok_o = ok_q;
  assign err_cnt_o    = cnt_q;
  assign corr_pulse_o = corr_q;
  assign retry_o      = retry_q;
  assign fatal_o      = fatal_q;

endmodule

// File: tb/tb_cv32e40p_mult_tmr_ctrl.sv
// Purpose:  directed bench for cv32e40p_mult_tmr_ctrl with a queue-based pulse scoreboard.
// Latency:  pulses are expected at hand-computed cycle stamps (corr +1, retry +2).
// Backpressure: not applicable; compare events are driven directly.
module tb_cv32e40p_mult_tmr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_i, ex_ready_i, ready_voted_i, clear_i;
  logic [95:0] result_tmr_i;
  logic [2:0]  ready_tmr_i, multicycle_tmr_i, mulh_tmr_i;
  logic [2:0]  replica_ok_o;
  logic [11:0] err_cnt_o;
  logic        corr_pulse_o, retry_o, fatal_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int corr_q[$];
  int retry_q[$];

  localparam logic [31:0] A = 32'h0000_1234;
  localparam logic [31:0] B = 32'h0000_FFFF;

  cv32e40p_mult_tmr_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable_i         (enable_i),
    .ex_ready_i       (ex_ready_i),
    .ready_voted_i    (ready_voted_i),
    .result_tmr_i     (result_tmr_i),
    .ready_tmr_i      (ready_tmr_i),
    .multicycle_tmr_i (multicycle_tmr_i),
    .mulh_tmr_i       (mulh_tmr_i),
    .clear_i          (clear_i),
    .replica_ok_o     (replica_ok_o),
    .err_cnt_o        (err_cnt_o),
    .corr_pulse_o     (corr_pulse_o),
    .retry_o          (retry_o),
    .fatal_o          (fatal_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic status(input string nm, input logic [11:0] ecnt, input logic [2:0] eok,
                        input logic efat);
    chk({nm, "_cnt"},   32'(err_cnt_o),    32'(ecnt));
    chk({nm, "_ok"},    32'(replica_ok_o), 32'(eok));
    chk({nm, "_fatal"}, 32'(fatal_o),      32'(efat));
  endtask

  // Called at a negedge; returns at the next negedge, after the sampling posedge.
  // ec/er: a corr pulse / retry pulse is expected from this vector.
  task automatic drive(input logic c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] d, input logic ec, input logic er,
                       input logic [2:0] mc = 3'b000, input logic clr = 1'b0,
                       input logic xr = 1'b1);
    enable_i         = c;
    ready_voted_i    = c;
    ex_ready_i       = c & xr;
    result_tmr_i     = {d, b, a};
    multicycle_tmr_i = mc;
    clear_i          = clr;
    if (ec) corr_q.push_back(cyc + 1);
    if (er) retry_q.push_back(cyc + 2);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, A, A, A, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: every pulse must match the oldest expected stamp; stale
  // expectations are reported as missing.
  always @(negedge clk) begin
    if (rst_n) begin
      while (corr_q.size() > 0 && corr_q[0] < cyc) begin
        checks++; errors++;
        $display("FAIL corr_missing expected at %0d now %0d", corr_q[0], cyc);
        void'(corr_q.pop_front());
      end
      if (corr_pulse_o) begin
        checks++;
        if (corr_q.size() == 0 || corr_q[0] != cyc) begin
          errors++;
          $display("FAIL corr_unexpected pulse at %0d exp %0d", cyc,
                   (corr_q.size() > 0) ? corr_q[0] : -1);
        end else void'(corr_q.pop_front());
      end
      while (retry_q.size() > 0 && retry_q[0] < cyc) begin
        checks++; errors++;
        $display("FAIL retry_missing expected at %0d now %0d", retry_q[0], cyc);
        void'(retry_q.pop_front());
      end
      if (retry_o) begin
        checks++;
        if (retry_q.size() == 0 || retry_q[0] != cyc) begin
          errors++;
          $display("FAIL retry_unexpected pulse at %0d exp %0d", cyc,
                   (retry_q.size() > 0) ? retry_q[0] : -1);
        end else void'(retry_q.pop_front());
      end
    end
  end

  initial begin
    rst_n            = 1'b0;
    enable_i         = 1'b0;
    ex_ready_i       = 1'b0;
    ready_voted_i    = 1'b0;
    clear_i          = 1'b0;
    result_tmr_i     = '0;
    ready_tmr_i      = 3'b111;
    multicycle_tmr_i = 3'b000;
    mulh_tmr_i       = 3'b000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    status("reset", 12'h000, 3'b111, 1'b0);
    chk("reset_corr", 32'(corr_pulse_o), 32'd0);
    chk("reset_retry", 32'(retry_o), 32'd0);

    // Agreeing replicas.
    for (int k = 0; k < 10; k++) drive(1'b1, A, A, A, 1'b0, 1'b0);
    status("agree", 12'h000, 3'b111, 1'b0);

    // Mismatch without a full compare event must be ignored.
    drive(1'b1, A, A ^ 32'd1, A, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    drive(1'b0, A, A ^ 32'd1, A, 1'b0, 1'b0);
    status("no_cmp", 12'h000, 3'b111, 1'b0);

    // Single error on replica 1, then decay after exactly DECAY_PERIOD idle cycles.
    drive(1'b1, A, A ^ 32'd1, A, 1'b1, 1'b0);
    status("r1_err", 12'h010, 3'b111, 1'b0);
    idle(1023);
    status("pre_decay", 12'h010, 3'b111, 1'b0);
    idle(1);
    status("decay", 12'h000, 3'b111, 1'b0);

    // Control-bit mismatch (multicycle) on replica 0, then clear.
    drive(1'b1, A, A, A, 1'b1, 1'b0, 3'b001);
    status("mc_err", 12'h001, 3'b111, 1'b0);
    drive(1'b0, A, A, A, 1'b0, 1'b0, 3'b000, 1'b1);
    status("clear1", 12'h000, 3'b111, 1'b0);

    // Replica 2 persistently wrong: faulty at the threshold, then frozen.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, A, A, B, 1'b1, 1'b0);
      if (k == 7) status("r2_seven", 12'h700, 3'b111, 1'b0);
    end
    status("r2_faulty", 12'h800, 3'b011, 1'b0);
    repeat (3) drive(1'b1, A, A, B, 1'b1, 1'b0);
    status("r2_frozen", 12'h800, 3'b011, 1'b0);

    // No majority: retry two cycles later, then an agreeing compare returns to MON.
    drive(1'b1, 32'd1, 32'd2, 32'd3, 1'b0, 1'b1);
    status("nomaj_cnt", 12'h800, 3'b011, 1'b0);
    idle(2);
    drive(1'b1, A, A, A, 1'b0, 1'b0);
    idle(1);
    // Three consecutive no-majority compares exhaust the retries.
    drive(1'b1, 32'd1, 32'd2, 32'd3, 1'b0, 1'b1);
    idle(2);
    drive(1'b1, 32'd4, 32'd5, 32'd6, 1'b0, 1'b1);
    idle(2);
    status("retry2", 12'h800, 3'b011, 1'b0);
    drive(1'b1, 32'd7, 32'd8, 32'd9, 1'b0, 1'b0);
    status("fatal_retry", 12'h800, 3'b011, 1'b1);
    idle(3);
    chk("fatal_sticky", 32'(fatal_o), 32'd1);
    drive(1'b0, A, A, A, 1'b0, 1'b0, 3'b000, 1'b1);
    status("clear2", 12'h000, 3'b111, 1'b0);
    drive(1'b1, 32'd1, 32'd2, 32'd3, 1'b0, 1'b1);
    idle(2);
    drive(1'b1, A, A, A, 1'b0, 1'b0);
    idle(1);

    // Two faulty replicas -> fatal.
    repeat (8) drive(1'b1, B, A, A, 1'b1, 1'b0);
    status("r0_faulty", 12'h008, 3'b110, 1'b0);
    repeat (8) drive(1'b1, A, A, B, 1'b1, 1'b0);
    status("two_faulty", 12'h808, 3'b010, 1'b0);
    idle(1);
    status("fatal_two", 12'h808, 3'b010, 1'b1);
    drive(1'b0, A, A, A, 1'b0, 1'b0, 3'b000, 1'b1);
    status("clear3", 12'h000, 3'b111, 1'b0);

    // clear_i beats a same-cycle increment.
    drive(1'b1, B, A, A, 1'b1, 1'b0);
    status("r0_one", 12'h001, 3'b111, 1'b0);
    drive(1'b1, B, A, A, 1'b0, 1'b0, 3'b000, 1'b1);
    status("clr_prio", 12'h000, 3'b111, 1'b0);

    // Asynchronous reset while a retry is being signalled.
    drive(1'b1, A, A ^ 32'd1, A, 1'b1, 1'b0);
    status("pre_rst", 12'h010, 3'b111, 1'b0);
    drive(1'b1, 32'd1, 32'd2, 32'd3, 1'b0, 1'b1);
    idle(1);
    chk("retry_high", 32'(retry_o), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("rst_retry", 32'(retry_o), 32'd0);
    status("rst", 12'h000, 3'b111, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'd1, 32'd2, 32'd3, 1'b0, 1'b1);
    idle(2);
    drive(1'b1, A, A, A, 1'b0, 1'b0);
    idle(3);

    chk("corr_q_empty", 32'(corr_q.size()), 32'd0);
    chk("retry_q_empty", 32'(retry_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
